// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default operand width and FSM state encoding.
package seq_divider_pkg;

  localparam int N_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_adder.sv
// Plain ripple-carry adder, w bits wide, with carry-in and carry-out.
module seq_divider_adder #(
  parameter int w = 33
) (
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  input  logic         cin,
  output logic [w-1:0] sum,
  output logic         cout
);

  always_comb begin
    logic carry;
    sum   = '0;
    carry = cin;
    for (int i = 0; i < w; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock, n+1 cycles from accept to done.
// Divide-by-zero short-circuits to DONE on the next cycle with quotient all ones.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         div_by_zero
);

  localparam int            CW   = $clog2(n + 1);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  state_t        state, state_nxt;
  logic [n-1:0]  dvd_sh, dvs_r, rem_r, quo_sh;
  logic [CW-1:0] cnt;

  logic [n:0]    trial_a, trial_b, trial_sum;
  logic          trial_cout, no_borrow;
  logic [n-1:0]  rem_nxt, quo_nxt;

  assign trial_a = {rem_r, dvd_sh[n-1]};
  assign trial_b = {1'b0, ~dvs_r};

  seq_divider_adder #(.w(n + 1)) u_sub (
    .a    (trial_a),
    .b    (trial_b),
    .cin  (1'b1),
    .sum  (trial_sum),
    .cout (trial_cout)
  );

  // With the complement zero-extended, sum = R + 2^n - divisor, so the
  // borrow-free case (R >= divisor) shows up as bit n of the sum.
  assign no_borrow = trial_sum[n] | trial_cout;
  assign rem_nxt   = no_borrow ? trial_sum[n-1:0] : trial_a[n-1:0];
  assign quo_nxt   = {quo_sh[n-2:0], no_borrow};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_sh      <= '0;
      dvs_r       <= '0;
      rem_r       <= '0;
      quo_sh      <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd_sh <= dividend;
            dvs_r  <= divisor;
            rem_r  <= '0;
            quo_sh <= '0;
            cnt    <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          dvd_sh <= {dvd_sh[n-2:0], 1'b0};
          rem_r  <= rem_nxt;
          quo_sh <= quo_nxt;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            quotient    <= quo_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_seq_divider;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [N-1:0] quotient, remainder;

  seq_divider #(.n(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic         rst_smp = 1'b1;
  int           busy_lo = 1;
  int           busy_hi = 0;
  logic [N-1:0] hold_q = '0;
  logic [N-1:0] hold_r = '0;
  logic         hold_z = 1'b0;

  // Inputs change #1 after the edge, so sampling here sees what the DUT saw.
  always @(posedge clk) begin
    cyc++;
    rst_smp = rst;
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_smp) begin
      chk("reset_quotient", quotient, '0);
      chk("reset_remainder", remainder, '0);
      chk("reset_dbz", div_by_zero, '0);
      chk("reset_busy", busy, '0);
      chk("reset_done", done, '0);
      hold_q = '0;
      hold_r = '0;
      hold_z = 1'b0;
    end else begin
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done cycle %0d: got done 1 expected 0", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("done_cycle", cyc, mon_e.cyc);
          chk("quotient", quotient, mon_e.q);
          chk("remainder", remainder, mon_e.r);
          chk("div_by_zero", div_by_zero, mon_e.z);
          hold_q = mon_e.q;
          hold_r = mon_e.r;
          hold_z = mon_e.z;
        end
      end else begin
        chk("hold_quotient", quotient, hold_q);
        chk("hold_remainder", remainder, hold_r);
        chk("hold_dbz", div_by_zero, hold_z);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout cycle %0d: got no done expected done within 200 cycles", cyc);
      sb.delete();
    end
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] eq, input logic [N-1:0] er, output int k);
    exp_t e;
    wait_idle();
    k     = cyc;
    e.q   = eq;
    e.r   = er;
    e.z   = (b == '0);
    e.cyc = k + ((b == '0) ? 1 : N + 1);
    sb.push_back(e);
    busy_lo  = k + 1;
    busy_hi  = (b == '0) ? k : k + N;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
  } vec_t;

  vec_t vecs[$] = '{
    '{32'd100,        32'd7,          32'd14,         32'd2},
    '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0},
    '{32'd3,          32'd10,         32'd0,          32'd3},
    '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5},
    '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0},
    '{32'hFFFFFFFF,   32'd10,         32'h19999999,   32'd5},
    '{32'd0,          32'd9,          32'd0,          32'd0},
    '{32'd12345678,   32'd1000,       32'd12345,      32'd678},
    '{32'h80000000,   32'd3,          32'd715827882,  32'd2},
    '{32'd7,          32'd7,          32'd1,          32'd0}
  };

  initial begin
    int k;
    logic [N-1:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, k);

    // A second start mid-run with different operands, then operand churn.
    issue(32'd1000, 32'd3, 32'd333, 32'd1, k);
    repeat (9) begin @(posedge clk); #1; end
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd9;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 32'hDEADBEEF;
    divisor  = 32'd0;

    // Start held during the DONE cycle must not launch another division.
    issue(32'd200, 32'd7, 32'd28, 32'd4, k);
    repeat (N) begin @(posedge clk); #1; end
    start    = 1'b1;
    dividend = 32'd8;
    divisor  = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // Abort mid-run: no done, everything back to zero.
    wait_idle();
    k        = cyc;
    busy_lo  = k + 1;
    busy_hi  = k + 15;
    dividend = 32'd1000;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(32'd50, 32'd5, 32'd10, 32'd0, k);

    // Reset and start on the same edge: reset wins.
    wait_idle();
    busy_lo  = 1;
    busy_hi  = 0;
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 32'd40;
    divisor  = 32'd4;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    issue(32'd40, 32'd4, 32'd10, 32'd0, k);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == '0) issue(a, b, '1, a, k);
      else         issue(a, b, a / b, a % b, k);
    end

    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
